// File: rtl/datapath_pkg.sv
// ============================================================================
// datapath_pkg : shared widths, ALU op bit positions and bus-select codes
// Revision    : 1.0
// ============================================================================
`default_nettype none

package datapath_pkg;

    localparam int DW    = 32;
    localparam int NREG  = 16;
    localparam int NSRC  = 24;
    localparam int ALU_W = 12;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_SHR  = 4;
    localparam int ALU_SHRA = 5;
    localparam int ALU_SHL  = 6;
    localparam int ALU_ROR  = 7;
    localparam int ALU_ROL  = 8;
    localparam int ALU_MUL  = 9;
    localparam int ALU_DIV  = 10;
    localparam int ALU_NOT  = 11;

    // Codes 0..15 select R0..R15 directly, so the GPR index is the code itself.
    typedef enum logic [4:0] {
        SEL_R0 = 5'd0, SEL_R1, SEL_R2, SEL_R3, SEL_R4, SEL_R5, SEL_R6, SEL_R7,
        SEL_R8, SEL_R9, SEL_R10, SEL_R11, SEL_R12, SEL_R13, SEL_R14, SEL_R15,
        SEL_HI, SEL_LO, SEL_ZHI, SEL_ZLO, SEL_PC, SEL_MDR, SEL_INPORT, SEL_C,
        SEL_NONE = 5'd31
    } bus_sel_e;

endpackage

`default_nettype wire

// File: rtl/datapath_alu.sv
// ============================================================================
// datapath_alu : combinational one-hot-controlled ALU, 64-bit {hi, lo} result
// Revision     : 1.0
// ============================================================================
`default_nettype none

module datapath_alu
    import datapath_pkg::*;
(
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [ALU_W-1:0] ctrl,
    output logic [2*DW-1:0]  result
);

    logic [4:0]      w_sh;
    logic [2*DW-1:0] w_prod;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic [DW-1:0]   w_div_b;
    logic [DW-1:0]   w_quot;
    logic [DW-1:0]   w_rem;
    logic [DW-1:0]   w_shra;
    logic [DW-1:0]   w_ror;
    logic [DW-1:0]   w_rol;

    assign w_sh   = b[4:0];
    assign w_prod = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};

    // Divisor is forced to 1 for /0 and MIN/-1 so the divider never traps;
    // MIN/1 then yields the wrapped quotient MIN with remainder 0.
    assign w_div_zero = (b == '0);
    assign w_div_ovf  = (a == {1'b1, {(DW-1){1'b0}}}) && (b == '1);
    assign w_div_b    = (w_div_zero || w_div_ovf) ? DW'(1) : b;
    assign w_quot     = $signed(a) / $signed(w_div_b);
    assign w_rem      = $signed(a) % $signed(w_div_b);

    assign w_shra = $signed(a) >>> w_sh;
    assign w_ror  = DW'({a, a} >> w_sh);
    assign w_rol  = DW'(({a, a} << w_sh) >> DW);

    always_comb begin
        result = '0;
        if ($onehot(ctrl)) begin
            if      (ctrl[ALU_ADD])  result[DW-1:0] = a + b;
            else if (ctrl[ALU_SUB])  result[DW-1:0] = a - b;
            else if (ctrl[ALU_AND])  result[DW-1:0] = a & b;
            else if (ctrl[ALU_OR])   result[DW-1:0] = a | b;
            else if (ctrl[ALU_SHR])  result[DW-1:0] = a >> w_sh;
            else if (ctrl[ALU_SHRA]) result[DW-1:0] = w_shra;
            else if (ctrl[ALU_SHL])  result[DW-1:0] = a << w_sh;
            else if (ctrl[ALU_ROR])  result[DW-1:0] = w_ror;
            else if (ctrl[ALU_ROL])  result[DW-1:0] = w_rol;
            else if (ctrl[ALU_MUL])  result         = w_prod;
            else if (ctrl[ALU_DIV])  result         = w_div_zero ? '0 : {w_rem, w_quot};
            else                     result[DW-1:0] = ~b;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_datapath_bus.sv
// ============================================================================
// cpu_datapath_bus : register file, priority-encoded shared bus, ALU and Z/MDR
// Revision         : 1.0
// ============================================================================
`default_nettype none

module cpu_datapath_bus
    import datapath_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    output logic [DW-1:0]    BusMuxOut,
    input  logic R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
    input  logic R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic R0in,   R1in,   R2in,   R3in,   R4in,   R5in,   R6in,   R7in,
    input  logic R8in,   R9in,   R10in,  R11in,  R12in,  R13in,  R14in,  R15in,
    input  logic             Zin,
    input  logic             Yin,
    input  logic             LOin,
    input  logic             HIin,
    input  logic             MDRin,
    output logic [DW-1:0] R0MuxIn,  R1MuxIn,  R2MuxIn,  R3MuxIn,
    output logic [DW-1:0] R4MuxIn,  R5MuxIn,  R6MuxIn,  R7MuxIn,
    output logic [DW-1:0] R8MuxIn,  R9MuxIn,  R10MuxIn, R11MuxIn,
    output logic [DW-1:0] R12MuxIn, R13MuxIn, R14MuxIn, R15MuxIn,
    input  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
    output logic [DW-1:0] HIMuxIn,  LOMuxIn,  ZhighMuxIn,  ZlowMuxIn,
    output logic [DW-1:0] PCMuxIn,  MDRMuxIn, InPortMuxIn, CMuxIn,
    input  logic [ALU_W-1:0] ALUControl,
    input  logic [DW-1:0]    Mdatain,
    input  logic             MDRRead,
    output logic [DW-1:0]    Yout
);

    logic [DW-1:0]   r_gpr [NREG];
    logic [DW-1:0]   r_hi, r_lo, r_y, r_zhi, r_zlo, r_mdr;
    logic [NSRC-1:0] w_strobe;
    logic [NREG-1:0] w_gpr_in;
    bus_sel_e        w_sel;
    logic [DW-1:0]   w_bus;
    logic [2*DW-1:0] w_alu;

    // Strobe bit position equals its select code; lower index = higher priority.
    assign w_strobe = {Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                       R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                       R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
    assign w_gpr_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                       R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

    always_comb begin
        w_sel = SEL_NONE;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_strobe[i]) w_sel = bus_sel_e'(5'(i));
        end
    end

    always_comb begin
        w_bus = '0;
        case (w_sel)
            SEL_HI:                          w_bus = r_hi;
            SEL_LO:                          w_bus = r_lo;
            SEL_ZHI:                         w_bus = r_zhi;
            SEL_ZLO:                         w_bus = r_zlo;
            SEL_MDR:                         w_bus = r_mdr;
            SEL_PC, SEL_INPORT, SEL_C, SEL_NONE: w_bus = '0;
            default:                         w_bus = r_gpr[w_sel[3:0]];
        endcase
    end

    datapath_alu u_alu (
        .a      (r_y),
        .b      (w_bus),
        .ctrl   (ALUControl),
        .result (w_alu)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_y   <= '0;
            r_zhi <= '0;
            r_zlo <= '0;
            r_mdr <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_gpr_in[i]) r_gpr[i] <= w_bus;
            end
            if (HIin)  r_hi <= w_bus;
            if (LOin)  r_lo <= w_bus;
            if (Yin)   r_y  <= w_bus;
            if (Zin)   {r_zhi, r_zlo} <= w_alu;
            if (MDRin) r_mdr <= MDRRead ? Mdatain : w_bus;
        end
    end

    assign BusMuxOut   = w_bus;
    assign Yout        = r_y;
    assign HIMuxIn     = r_hi;
    assign LOMuxIn     = r_lo;
    assign ZhighMuxIn  = r_zhi;
    assign ZlowMuxIn   = r_zlo;
    assign MDRMuxIn    = r_mdr;
    assign PCMuxIn     = '0;
    assign InPortMuxIn = '0;
    assign CMuxIn      = '0;

    assign R0MuxIn  = r_gpr[0];
    assign R1MuxIn  = r_gpr[1];
    assign R2MuxIn  = r_gpr[2];
    assign R3MuxIn  = r_gpr[3];
    assign R4MuxIn  = r_gpr[4];
    assign R5MuxIn  = r_gpr[5];
    assign R6MuxIn  = r_gpr[6];
    assign R7MuxIn  = r_gpr[7];
    assign R8MuxIn  = r_gpr[8];
    assign R9MuxIn  = r_gpr[9];
    assign R10MuxIn = r_gpr[10];
    assign R11MuxIn = r_gpr[11];
    assign R12MuxIn = r_gpr[12];
    assign R13MuxIn = r_gpr[13];
    assign R14MuxIn = r_gpr[14];
    assign R15MuxIn = r_gpr[15];

endmodule

`default_nettype wire

// File: tb/tb_cpu_datapath_bus.sv
// ============================================================================
// tb_cpu_datapath_bus : directed and random checks against a behavioural model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_datapath_bus;

    logic        clk;
    logic        clr;
    logic [15:0] rout, rin;
    logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout;
    logic        Zin, Yin, LOin, HIin, MDRin, MDRRead;
    logic [11:0] ALUControl;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut, Yout;
    logic [31:0] rmux [16];
    logic [31:0] HIMuxIn, LOMuxIn, ZhighMuxIn, ZlowMuxIn, PCMuxIn, MDRMuxIn, InPortMuxIn, CMuxIn;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_gpr [16];
    logic [31:0] m_hi, m_lo, m_y, m_zhi, m_zlo, m_mdr;

    cpu_datapath_bus dut (
        .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .Zin(Zin), .Yin(Yin), .LOin(LOin), .HIin(HIin), .MDRin(MDRin),
        .R0MuxIn(rmux[0]),   .R1MuxIn(rmux[1]),   .R2MuxIn(rmux[2]),   .R3MuxIn(rmux[3]),
        .R4MuxIn(rmux[4]),   .R5MuxIn(rmux[5]),   .R6MuxIn(rmux[6]),   .R7MuxIn(rmux[7]),
        .R8MuxIn(rmux[8]),   .R9MuxIn(rmux[9]),   .R10MuxIn(rmux[10]), .R11MuxIn(rmux[11]),
        .R12MuxIn(rmux[12]), .R13MuxIn(rmux[13]), .R14MuxIn(rmux[14]), .R15MuxIn(rmux[15]),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
        .HIMuxIn(HIMuxIn), .LOMuxIn(LOMuxIn), .ZhighMuxIn(ZhighMuxIn), .ZlowMuxIn(ZlowMuxIn),
        .PCMuxIn(PCMuxIn), .MDRMuxIn(MDRMuxIn), .InPortMuxIn(InPortMuxIn), .CMuxIn(CMuxIn),
        .ALUControl(ALUControl), .Mdatain(Mdatain), .MDRRead(MDRRead), .Yout(Yout)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_bus();
        for (int i = 0; i < 16; i++) if (rout[i]) return m_gpr[i];
        if (HIout)     return m_hi;
        if (LOout)     return m_lo;
        if (Zhighout)  return m_zhi;
        if (Zlowout)   return m_zlo;
        if (PCout)     return 32'h0;
        if (MDRout)    return m_mdr;
        return 32'h0;
    endfunction

    // Reference ALU: picks the op number, then evaluates it with plain arithmetic.
    function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [11:0] c);
        int          op = -1;
        int          sa, sb, sh;
        longint      p, q, rm;
        logic [31:0] x;
        logic [63:0] r = 64'h0;
        sa = a;
        sb = b;
        sh = int'(b[4:0]);
        if ($countones(c) == 1)
            for (int k = 0; k < 12; k++) if (c[k]) op = k;
        case (op)
            0:  r[31:0] = a + b;
            1:  r[31:0] = a - b;
            2:  r[31:0] = a & b;
            3:  r[31:0] = a | b;
            4:  r[31:0] = a >> sh;
            5:  r[31:0] = sa >>> sh;
            6:  r[31:0] = a << sh;
            7:  begin x = a; repeat (sh) x = {x[0], x[31:1]}; r[31:0] = x; end
            8:  begin x = a; repeat (sh) x = {x[30:0], x[31]}; r[31:0] = x; end
            9:  begin p = longint'(sa) * longint'(sb); r = p; end
            10: if (b != 32'h0) begin
                    q  = longint'(sa) / longint'(sb);
                    rm = longint'(sa) % longint'(sb);
                    r  = {rm[31:0], q[31:0]};
                end
            11: r[31:0] = ~b;
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    task automatic clear_ctrl();
        rout = '0; rin = '0;
        {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout} = '0;
        {Zin, Yin, LOin, HIin, MDRin, MDRRead} = '0;
        ALUControl = '0;
        Mdatain = '0;
    endtask

    task automatic check_state();
        for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), rmux[i], m_gpr[i]);
        chk("HI", HIMuxIn, m_hi);
        chk("LO", LOMuxIn, m_lo);
        chk("Zhigh", ZhighMuxIn, m_zhi);
        chk("Zlow", ZlowMuxIn, m_zlo);
        chk("MDR", MDRMuxIn, m_mdr);
        chk("PC", PCMuxIn, 32'h0);
        chk("InPort", InPortMuxIn, 32'h0);
        chk("C", CMuxIn, 32'h0);
        chk("Y", Yout, m_y);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gpr[i] = '0;
        {m_hi, m_lo, m_y, m_zhi, m_zlo, m_mdr} = '0;
    endtask

    // One clock: check the bus mid-cycle, advance the model at the edge, recheck state.
    task automatic step();
        logic [31:0] bus;
        logic [63:0] alu;
        @(negedge clk);
        bus = m_bus();
        chk("bus", BusMuxOut, bus);
        alu = m_alu(m_y, bus, ALUControl);
        @(posedge clk);
        for (int i = 0; i < 16; i++) if (rin[i]) m_gpr[i] = bus;
        if (HIin)  m_hi = bus;
        if (LOin)  m_lo = bus;
        if (Yin)   m_y  = bus;
        if (Zin)   {m_zhi, m_zlo} = alu;
        if (MDRin) m_mdr = MDRRead ? Mdatain : bus;
        #1;
        check_state();
        clear_ctrl();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; MDRRead = 1'b1; MDRin = 1'b1;
        step();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] v);
        load_mdr(v);
        MDRout = 1'b1; rin[idx] = 1'b1;
        step();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        MDRout = 1'b1; Yin = 1'b1;
        step();
    endtask

    task automatic alu_op(input int src, input logic [11:0] ctl);
        rout[src] = 1'b1; ALUControl = ctl; Zin = 1'b1;
        step();
    endtask

    initial begin
        int src;
        clear_ctrl();
        model_reset();
        clr = 1'b0;
        #1;
        check_state();
        chk("reset_bus", BusMuxOut, 32'h0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;

        // MDR load from memory, then move to R2
        load_mdr(32'h29);
        chk("mdr_load", MDRMuxIn, 32'h29);
        MDRout = 1'b1; rin[2] = 1'b1;
        step();
        chk("r2_from_mdr", rmux[2], 32'h29);

        // SHR path: Y=R2, R4=3, Z = Y >> 3, R5 = Zlow
        load_reg(4, 32'd3);
        rout[2] = 1'b1; Yin = 1'b1;
        step();
        chk("shr_y", Yout, 32'h29);
        alu_op(4, 12'h010);
        chk("shr_zlow", ZlowMuxIn, 32'h5);
        chk("shr_zhigh", ZhighMuxIn, 32'h0);
        Zlowout = 1'b1; rin[5] = 1'b1;
        step();
        chk("shr_r5", rmux[5], 32'h5);

        // MUL / DIV / DIV by zero
        load_y(32'hFFFF_FFFE);
        alu_op(4, 12'h200);
        chk("mul_zhigh", ZhighMuxIn, 32'hFFFF_FFFF);
        chk("mul_zlow", ZlowMuxIn, 32'hFFFF_FFFA);
        load_reg(6, 32'd2);
        load_y(32'd7);
        alu_op(6, 12'h400);
        chk("div_zlow", ZlowMuxIn, 32'd3);
        chk("div_zhigh", ZhighMuxIn, 32'd1);
        ALUControl = 12'h400; Zin = 1'b1;
        step();
        chk("div0_zlow", ZlowMuxIn, 32'h0);
        chk("div0_zhigh", ZhighMuxIn, 32'h0);

        // Bus priority
        load_reg(3, 32'h0000_0033);
        load_mdr(32'h0000_00AA);
        rout[3] = 1'b1; MDRout = 1'b1;
        #1 chk("prio_r3_over_mdr", BusMuxOut, 32'h33);
        clear_ctrl();
        #1 chk("no_strobe", BusMuxOut, 32'h0);
        PCout = 1'b1;
        #1 chk("pc_only", BusMuxOut, 32'h0);
        step();

        // Rotate and ADD wraparound
        load_reg(7, 32'd1);
        load_y(32'h8000_0001);
        alu_op(7, 12'h100);
        chk("rol_zlow", ZlowMuxIn, 32'h0000_0003);
        load_y(32'hFFFF_FFFF);
        alu_op(7, 12'h001);
        chk("add_wrap_zlow", ZlowMuxIn, 32'h0);
        chk("add_wrap_zhigh", ZhighMuxIn, 32'h0);

        // Same-cycle read/write of one register keeps the old value
        rout[2] = 1'b1; rin[2] = 1'b1; Yin = 1'b1;
        step();
        chk("rw_same_r2", rmux[2], 32'h29);

        // Asynchronous reset mid-cycle
        rout[2] = 1'b1;
        #4 clr = 1'b0;
        #1;
        model_reset();
        chk("areset_r2", rmux[2], 32'h0);
        chk("areset_bus", BusMuxOut, 32'h0);
        check_state();
        @(negedge clk);
        clr = 1'b1;
        clear_ctrl();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            src = $urandom_range(0, 26);
            if (src < 16) rout[src] = 1'b1;
            else case (src)
                16: HIout = 1'b1;   17: LOout = 1'b1;
                18: Zhighout = 1'b1; 19: Zlowout = 1'b1;
                20: PCout = 1'b1;   21: MDRout = 1'b1;
                22: InPortout = 1'b1; 23: Cout = 1'b1;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) rout[$urandom_range(0, 15)] = 1'b1;
            rin     = 16'($urandom) & 16'($urandom);
            {Zin, Yin, LOin, HIin} = 4'($urandom);
            MDRin   = ($urandom_range(0, 2) != 0);
            MDRRead = ($urandom_range(0, 1) != 0);
            Mdatain = (n % 5 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            ALUControl = ($urandom_range(0, 7) != 0) ? 12'(1) << $urandom_range(0, 11)
                                                     : 12'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
